// File: rtl/led_display_frame_writer_if.sv
// Pixel-stream and frame-RAM port A bundle for the LED frame writer.
// slave: the writer (consumes pixels, drives RAM); master: pixel source / RAM side.
`timescale 1ns/1ps

interface led_display_frame_writer_if;
    logic [2:0]  pix_data_in;
    logic        pix_valid_in;
    logic        pix_ready_out;
    logic        pix_sof_in;
    logic        pix_eol_in;
    logic [3:0]  ram_wen_out;
    logic [31:0] ram_addr_out;
    logic [31:0] ram_wdata_out;

    modport slave (
        input  pix_data_in,
        input  pix_valid_in,
        output pix_ready_out,
        input  pix_sof_in,
        input  pix_eol_in,
        output ram_wen_out,
        output ram_addr_out,
        output ram_wdata_out
    );

    modport master (
        output pix_data_in,
        output pix_valid_in,
        input  pix_ready_out,
        output pix_sof_in,
        output pix_eol_in,
        input  ram_wen_out,
        input  ram_addr_out,
        input  ram_wdata_out
    );
endinterface

// File: rtl/led_display_frame_writer.sv
// Packs a 3-bit RGB pixel stream into 32-bit words and writes whole frames into a double buffer.
// Optional saturating frame/error counters are built when LED_FRAME_WRITER_STATS_EN is defined.
`timescale 1ns/1ps

module led_display_frame_writer #(
    parameter int unsigned NUM_ROW_PIXELS = 32,
    parameter int unsigned NUM_COL_PIXELS = 64,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic                              clk_in,
    input  logic                              n_reset_in,
    led_display_frame_writer_if.slave         bus,
    output logic                              buffer_sel_out,
    output logic                              frame_done_out,
    output logic                              frame_error_out
`ifdef LED_FRAME_WRITER_STATS_EN
    ,
    output logic [15:0]                       frame_count_out,
    output logic [15:0]                       error_count_out
`endif
);

    localparam int unsigned WORDS_PER_ROW = NUM_COL_PIXELS / 8;
    localparam int unsigned FRAME_WORDS   = NUM_ROW_PIXELS * WORDS_PER_ROW;
    localparam logic [31:0] FRAME_BYTES   = 32'(FRAME_WORDS * 4);
    localparam int COL_W  = $clog2(NUM_COL_PIXELS);
    localparam int ROW_W  = (NUM_ROW_PIXELS > 1) ? $clog2(NUM_ROW_PIXELS) : 1;
    localparam int WIDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COL_PIXELS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROW_PIXELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_SWAP   = 2'd2
    } state_t;

    state_t            state_r;
    logic [COL_W-1:0]  col_r;
    logic [ROW_W-1:0]  row_r;
    logic [WIDX_W-1:0] widx_r;
    logic [31:0]       pack_r;
    logic              ready_r;
    logic [3:0]        ram_wen_r;
    logic [31:0]       ram_addr_r;
    logic [31:0]       ram_wdata_r;
    logic              buffer_sel_r;
    logic              frame_done_r;
    logic              frame_error_r;

    logic              accept_s;
    logic              in_frame_s;
    logic [COL_W-1:0]  eff_col_s;
    logic [ROW_W-1:0]  eff_row_s;
    logic [WIDX_W-1:0] eff_widx_s;
    logic [31:0]       word_s;
    logic              last_col_s;
    logic              last_row_s;
    logic              eol_err_s;
    logic              sof_err_s;
    logic              word_full_s;
    logic [31:0]       addr_s;

    // Decode the offered pixel: a SOF pixel always lands at row 0 / col 0 of a fresh word.
    always_comb begin
        accept_s   = bus.pix_valid_in & ready_r;
        eff_col_s  = col_r;
        eff_row_s  = row_r;
        eff_widx_s = widx_r;
        word_s     = pack_r;
        if (bus.pix_sof_in) begin
            eff_col_s  = {COL_W{1'b0}};
            eff_row_s  = {ROW_W{1'b0}};
            eff_widx_s = {WIDX_W{1'b0}};
            word_s     = 32'h0000_0000;
        end else begin
            eff_col_s  = col_r;
            eff_row_s  = row_r;
            eff_widx_s = widx_r;
            word_s     = pack_r;
        end
        word_s[{eff_col_s[2:0], 2'b00} +: 4] = {1'b0, bus.pix_data_in};
        in_frame_s  = accept_s & (bus.pix_sof_in | (state_r == ST_ACTIVE));
        last_col_s  = (eff_col_s == LAST_COL);
        last_row_s  = (eff_row_s == LAST_ROW);
        eol_err_s   = in_frame_s & (bus.pix_eol_in != last_col_s);
        sof_err_s   = accept_s & bus.pix_sof_in & (state_r == ST_ACTIVE);
        word_full_s = (eff_col_s[2:0] == 3'd7);
        // The write buffer is always the one the reader is not showing.
        addr_s = BASE_ADDR + (buffer_sel_r ? 32'h0000_0000 : FRAME_BYTES)
               + 32'({eff_widx_s, 2'b00});
    end

    // Frame FSM with registered handshake, RAM port and status outputs.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_r       <= ST_IDLE;
            col_r         <= {COL_W{1'b0}};
            row_r         <= {ROW_W{1'b0}};
            widx_r        <= {WIDX_W{1'b0}};
            pack_r        <= 32'h0000_0000;
            ready_r       <= 1'b0;
            ram_wen_r     <= 4'h0;
            ram_addr_r    <= 32'h0000_0000;
            ram_wdata_r   <= 32'h0000_0000;
            buffer_sel_r  <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            ram_wen_r     <= 4'h0;
            frame_done_r  <= 1'b0;
            frame_error_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_ACTIVE: begin
                    ready_r <= 1'b1;
                    if (in_frame_s) begin
                        if (eol_err_s) begin
                            // Misplaced or missing EOL: drop the frame and any word in flight.
                            frame_error_r <= 1'b1;
                            state_r       <= ST_IDLE;
                        end else begin
                            frame_error_r <= sof_err_s;
                            if (word_full_s) begin
                                ram_wen_r   <= 4'hF;
                                ram_addr_r  <= addr_s;
                                ram_wdata_r <= word_s;
                                pack_r      <= 32'h0000_0000;
                                widx_r      <= eff_widx_s + 1'b1;
                            end else begin
                                pack_r      <= word_s;
                                widx_r      <= eff_widx_s;
                            end
                            if (last_col_s) begin
                                col_r <= {COL_W{1'b0}};
                                row_r <= eff_row_s + 1'b1;
                                if (last_row_s) begin
                                    state_r <= ST_SWAP;
                                    ready_r <= 1'b0;
                                end else begin
                                    state_r <= ST_ACTIVE;
                                end
                            end else begin
                                col_r   <= eff_col_s + 1'b1;
                                row_r   <= eff_row_s;
                                state_r <= ST_ACTIVE;
                            end
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_SWAP: begin
                    buffer_sel_r <= ~buffer_sel_r;
                    frame_done_r <= 1'b1;
                    ready_r      <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pix_ready_out = ready_r;
    assign bus.ram_wen_out   = ram_wen_r;
    assign bus.ram_addr_out  = ram_addr_r;
    assign bus.ram_wdata_out = ram_wdata_r;
    assign buffer_sel_out    = buffer_sel_r;
    assign frame_done_out    = frame_done_r;
    assign frame_error_out   = frame_error_r;

`ifdef LED_FRAME_WRITER_STATS_EN
    logic [15:0] frame_count_r;
    logic [15:0] error_count_r;

    // Saturating counters of completed frames and framing errors.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            frame_count_r <= 16'h0000;
            error_count_r <= 16'h0000;
        end else begin
            if (frame_done_r && (frame_count_r != 16'hFFFF)) begin
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
            if (frame_error_r && (error_count_r != 16'hFFFF)) begin
                error_count_r <= error_count_r + 16'd1;
            end else begin
                error_count_r <= error_count_r;
            end
        end
    end

    assign frame_count_out = frame_count_r;
    assign error_count_out = error_count_r;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_led_display_frame_writer.sv
// Directed bench for led_display_frame_writer: expected RAM writes are queued as pixels are driven
// and popped by a write monitor; frame status is checked after each scenario.
`timescale 1ns/1ps

module tb_led_display_frame_writer;
    localparam int ROWS     = 32;
    localparam int COLS     = 64;
    localparam int FRAME_PX = ROWS * COLS;
    localparam logic [31:0] FRAME_BYTES = 32'h0000_0400;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk     = 1'b0;
    logic n_reset = 1'b0;
    logic buffer_sel;
    logic frame_done;
    logic frame_error;
`ifdef LED_FRAME_WRITER_STATS_EN
    logic [15:0] frame_count;
    logic [15:0] error_count;
`endif

    led_display_frame_writer_if bus ();

    led_display_frame_writer #(
        .NUM_ROW_PIXELS (ROWS),
        .NUM_COL_PIXELS (COLS),
        .BASE_ADDR      (32'h0000_0000)
    ) dut (
        .clk_in          (clk),
        .n_reset_in      (n_reset),
        .bus             (bus),
        .buffer_sel_out  (buffer_sel),
        .frame_done_out  (frame_done),
        .frame_error_out (frame_error)
`ifdef LED_FRAME_WRITER_STATS_EN
        ,
        .frame_count_out (frame_count),
        .error_count_out (error_count)
`endif
    );

    always #5 clk = ~clk;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    int          n_done   = 0;
    int          n_err    = 0;
    logic        exp_sel  = 1'b0;
    logic [31:0] acc      = 32'h0000_0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Write monitor / scoreboard and status pulse counters
    always @(negedge clk) begin
        if (frame_done === 1'b1) n_done++;
        if (frame_error === 1'b1) n_err++;
        if (bus.ram_wen_out !== 4'h0) begin
            wr_t w;
            n_writes++;
            check("wen", 32'(bus.ram_wen_out), 32'h0000_000F);
            check("write_expected", 32'(exp_q.size() > 0), 32'h1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("wr_addr", bus.ram_addr_out, w.addr);
                check("wr_data", bus.ram_wdata_out, w.data);
            end
        end
    end

    task automatic send_px(input logic [2:0] d, input logic sof, input logic eol);
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.pix_ready_out !== 1'b1 && guard < 16) begin
            bus.pix_valid_in = 1'b0;
            @(negedge clk);
            guard++;
        end
        if (guard >= 16) check("ready_timeout", 32'(bus.pix_ready_out), 32'h1);
        bus.pix_data_in  = d;
        bus.pix_sof_in   = sof;
        bus.pix_eol_in   = eol;
        bus.pix_valid_in = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.pix_valid_in = 1'b0;
            bus.pix_sof_in   = 1'b0;
            bus.pix_eol_in   = 1'b0;
        end
    endtask

    // Drive frame positions from..to; pos 0 carries SOF; completed words are queued as expected writes.
    task automatic send_range(input int from, input int to, input bit rnd, input bit thr, input int bad_pos);
        logic [2:0] d;
        logic       eol;
        wr_t        w;
        for (int pos = from; pos <= to; pos++) begin
            if (thr && ($urandom_range(0, 1) == 0)) begin
                @(negedge clk);
                bus.pix_valid_in = 1'b0;
            end
            d   = rnd ? 3'($urandom_range(0, 7)) : 3'(pos % 8);
            eol = ((pos % COLS) == (COLS - 1)) || (pos == bad_pos);
            send_px(d, (pos == 0), eol);
            acc[4*(pos%8) +: 4] = {1'b0, d};
            if (((pos % 8) == 7) && ((bad_pos < 0) || (pos < bad_pos))) begin
                w.addr = (exp_sel ? 32'h0000_0000 : FRAME_BYTES) + 32'(pos / 8) * 32'd4;
                w.data = acc;
                exp_q.push_back(w);
                acc = 32'h0000_0000;
            end
        end
    endtask

    task automatic strays(input int n);
        for (int i = 0; i < n; i++) send_px(3'(i), 1'b0, (i == 1));
    endtask

    initial begin
        int w0;
        int d0;
        int e0;
        bus.pix_data_in  = 3'd0;
        bus.pix_valid_in = 1'b0;
        bus.pix_sof_in   = 1'b0;
        bus.pix_eol_in   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_ready", 32'(bus.pix_ready_out), 32'h0);
        check("rst_wen",   32'(bus.ram_wen_out), 32'h0);
        check("rst_addr",  bus.ram_addr_out, 32'h0);
        check("rst_wdata", bus.ram_wdata_out, 32'h0);
        check("rst_sel",   32'(buffer_sel), 32'h0);
        check("rst_done",  32'(frame_done), 32'h0);
        check("rst_error", 32'(frame_error), 32'h0);
`ifdef LED_FRAME_WRITER_STATS_EN
        check("rst_fcnt", 32'(frame_count), 32'h0);
        check("rst_ecnt", 32'(error_count), 32'h0);
`endif
        n_reset = 1'b1;

        // Single frame into buffer 1
        w0 = n_writes; d0 = n_done; e0 = n_err;
        send_range(0, FRAME_PX - 1, 1'b0, 1'b0, -1);
        idle(6);
        check("f1_writes", 32'(n_writes - w0), 32'd256);
        check("f1_done",   32'(n_done - d0), 32'd1);
        check("f1_err",    32'(n_err - e0), 32'd0);
        check("f1_sel",    32'(buffer_sel), 32'h1);
        check("f1_pending", 32'(exp_q.size()), 32'd0);
        check("f1_addr_hold",  bus.ram_addr_out, 32'h0000_07FC);
        check("f1_wdata_hold", bus.ram_wdata_out, 32'h7654_3210);
        check("f1_wen_idle",   32'(bus.ram_wen_out), 32'h0);
        exp_sel = 1'b1;

        // Second frame, random data, into buffer 0
        w0 = n_writes; d0 = n_done; e0 = n_err;
        send_range(0, FRAME_PX - 1, 1'b1, 1'b0, -1);
        idle(6);
        check("f2_writes", 32'(n_writes - w0), 32'd256);
        check("f2_done",   32'(n_done - d0), 32'd1);
        check("f2_sel",    32'(buffer_sel), 32'h0);
        check("f2_addr_hold", bus.ram_addr_out, 32'h0000_03FC);
        check("f2_pending", 32'(exp_q.size()), 32'd0);
        exp_sel = 1'b0;

        // EOL at col 40 of row 3, then stray pixels that must not write
        w0 = n_writes; d0 = n_done; e0 = n_err;
        send_range(0, 3 * COLS + 40, 1'b0, 1'b0, 3 * COLS + 40);
        idle(4);
        strays(5);
        idle(6);
        check("eol_writes", 32'(n_writes - w0), 32'd29);
        check("eol_err",    32'(n_err - e0), 32'd1);
        check("eol_done",   32'(n_done - d0), 32'd0);
        check("eol_sel",    32'(buffer_sel), 32'h0);
        check("eol_pending", 32'(exp_q.size()), 32'd0);

        // SOF at row 10 col 0 restarts the frame, which then completes
        w0 = n_writes; d0 = n_done; e0 = n_err;
        send_range(0, 10 * COLS - 1, 1'b1, 1'b0, -1);
        send_range(0, FRAME_PX - 1, 1'b1, 1'b0, -1);
        idle(6);
        check("sof_writes", 32'(n_writes - w0), 32'd336);
        check("sof_err",    32'(n_err - e0), 32'd1);
        check("sof_done",   32'(n_done - d0), 32'd1);
        check("sof_sel",    32'(buffer_sel), 32'h1);
        check("sof_pending", 32'(exp_q.size()), 32'd0);
        exp_sel = 1'b1;
`ifdef LED_FRAME_WRITER_STATS_EN
        check("stat_fcnt", 32'(frame_count), 32'd3);
        check("stat_ecnt", 32'(error_count), 32'd2);
`endif

        // Reset in row 16
        w0 = n_writes;
        send_range(0, 16 * COLS + 3, 1'b0, 1'b0, -1);
        @(negedge clk);
        #2;
        n_reset = 1'b0;
        bus.pix_valid_in = 1'b0;
        #1;
        check("mid_writes", 32'(n_writes - w0), 32'd128);
        check("mid_ready", 32'(bus.pix_ready_out), 32'h0);
        check("mid_wen",   32'(bus.ram_wen_out), 32'h0);
        check("mid_addr",  bus.ram_addr_out, 32'h0);
        check("mid_wdata", bus.ram_wdata_out, 32'h0);
        check("mid_sel",   32'(buffer_sel), 32'h0);
        check("mid_done",  32'(frame_done), 32'h0);
        check("mid_error", 32'(frame_error), 32'h0);
`ifdef LED_FRAME_WRITER_STATS_EN
        check("mid_fcnt", 32'(frame_count), 32'h0);
        check("mid_ecnt", 32'(error_count), 32'h0);
`endif
        exp_sel = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;

        // Throttled valid with stray pixels first: same image as the first frame
        w0 = n_writes; d0 = n_done; e0 = n_err;
        strays(4);
        send_range(0, FRAME_PX - 1, 1'b0, 1'b1, -1);
        idle(6);
        check("thr_writes", 32'(n_writes - w0), 32'd256);
        check("thr_done",   32'(n_done - d0), 32'd1);
        check("thr_err",    32'(n_err - e0), 32'd0);
        check("thr_sel",    32'(buffer_sel), 32'h1);
        check("thr_pending", 32'(exp_q.size()), 32'd0);
        check("thr_addr_hold", bus.ram_addr_out, 32'h0000_07FC);
`ifdef LED_FRAME_WRITER_STATS_EN
        check("thr_fcnt", 32'(frame_count), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
